// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM memory-stage bridge.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 19;
  localparam int unsigned SRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } sram_state_t;

endpackage

// File: rtl/sram_read_buf.sv
// One-entry read buffer (valid bit, word address, data) used by
// sram_controller when SRAM_READ_BUF_EN is defined.
module sram_read_buf
  import sram_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  // lookup
  input  logic [SRAM_ADDR_W-1:0] lookup_addr,
  output logic                   lookup_hit,
  output logic [SRAM_DATA_W-1:0] lookup_data,
  // fill on every completed read
  input  logic                   fill_en,
  input  logic [SRAM_ADDR_W-1:0] fill_addr,
  input  logic [SRAM_DATA_W-1:0] fill_data,
  // write-update keeps the entry coherent with SRAM
  input  logic                   upd_en,
  input  logic [SRAM_ADDR_W-1:0] upd_addr,
  input  logic [SRAM_DATA_W-1:0] upd_data
);

  logic                   buf_valid;
  logic [SRAM_ADDR_W-1:0] buf_addr;
  logic [SRAM_DATA_W-1:0] buf_data;

  // Entry update: fill on read completion, refresh data on a matching write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fill_en) begin
      buf_valid <= 1'b1;
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
    end else if (upd_en && buf_valid && (upd_addr == buf_addr)) begin
      buf_data  <= upd_data;
    end
  end

  assign lookup_hit  = buf_valid && (buf_addr == lookup_addr);
  assign lookup_data = buf_data;

endmodule

// File: rtl/sram_controller.sv
// MEM-stage to external SRAM bridge: one FSM (IDLE/ACCESS/DONE) plus a
// wait-state counter. Optional read buffer enabled by SRAM_READ_BUF_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_Addr,
  output logic                   SRAM_WE_N,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

  sram_state_t            state, state_nxt;
  logic [3:0]             cnt;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [SRAM_DATA_W-1:0] data_q;
  logic                   wr_q;
  logic [SRAM_DATA_W-1:0] rdata_q;
  logic [SRAM_ADDR_W-1:0] word_addr;
  logic                   req;
  logic                   buf_hit;
  logic                   start;
  logic                   last_edge;
  logic                   dq_oe;

  assign word_addr = SRAM_ADDR_W'((address - BASE_ADDR) >> 2);
  assign req       = rd_en | wr_en;
  assign start     = (state == IDLE) && req && !buf_hit;
  assign last_edge = (state == ACCESS) && (cnt == '0);

`ifdef SRAM_READ_BUF_EN
  logic                   lookup_hit;
  logic [SRAM_DATA_W-1:0] lookup_data;

  sram_read_buf u_read_buf (
    .clk         (clk),
    .rst_n       (rst),
    .lookup_addr (word_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .fill_en     (last_edge && !wr_q),
    .fill_addr   (addr_q),
    .fill_data   (SRAM_DQ),
    .upd_en      (last_edge && wr_q),
    .upd_addr    (addr_q),
    .upd_data    (data_q)
  );

  // A buffer hit is served in IDLE without leaving the state.
  assign buf_hit = (state == IDLE) && rd_en && !wr_en && lookup_hit;
  assign rdata   = buf_hit ? lookup_data : rdata_q;
`else
  assign buf_hit = 1'b0;
  assign rdata   = rdata_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait-state counter and read-data latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt    <= 4'(WAIT_CYCLES - 1);
            addr_q <= word_addr;
            data_q <= wdata;
            wr_q   <= wr_en;
          end
        end
        ACCESS: begin
          if (cnt != '0)  cnt     <= cnt - 4'd1;
          else if (!wr_q) rdata_q <= SRAM_DQ;
        end
        default: ;
      endcase
    end
  end

  // Outputs: ready, SRAM strobes and address mux.
  always_comb begin
    ready     = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    SRAM_Addr = word_addr;
    unique case (state)
      IDLE:    ready = !req || buf_hit;
      ACCESS: begin
        ready     = 1'b0;
        SRAM_WE_N = !wr_q;
        dq_oe     = wr_q;
        SRAM_Addr = addr_q;
      end
      DONE:    SRAM_Addr = addr_q;
      default: ;
    endcase
    // In IDLE the address path is combinational from the input, so reset
    // has to gate it explicitly to present zero.
    if (!rst) SRAM_Addr = '0;
  end

  assign SRAM_DQ = dq_oe ? data_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM and a
// transaction-level reference model. Define SRAM_READ_BUF_EN to cover the
// read buffer.
module tb_sram_controller;

  localparam int unsigned WAIT = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [18:0] SRAM_Addr;
  logic        SRAM_WE_N;
  wire  [31:0] SRAM_DQ;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_Addr (SRAM_Addr),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_DQ   (SRAM_DQ)
  );

  // Behavioural asynchronous SRAM device.
  logic [31:0] sram_mem [0:524287];
  logic [31:0] tb_dq;
  assign tb_dq   = sram_mem[SRAM_Addr];
  assign SRAM_DQ = SRAM_WE_N ? tb_dq : 'z;
  always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_Addr] <= SRAM_DQ;

  // Reference model state.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rdata;
  bit          buf_valid;
  logic [18:0] buf_word;
  time         t_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [18:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 19'(off / 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [18:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return 32'h0;
  endfunction

  // One pipeline request; inputs change just after a rising edge,
  // outputs are sampled on falling edges.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
    logic [18:0] w;
    bit          hit;
    bit          done;
    bit          addr_bad;
    int unsigned stall, we_low;
    logic [31:0] exp_data;
    w = word_of(a);
    hit = 1'b0; done = 1'b0; addr_bad = 1'b0; stall = 0; we_low = 0;
`ifdef SRAM_READ_BUF_EN
    hit = !wr && buf_valid && (buf_word == w);
`endif
    rd_en = rd; wr_en = wr; address = a; wdata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (SRAM_Addr !== w) addr_bad = 1'b1;
      if (ready === 1'b1) begin
        done = 1'b1;
        t_ready = $time;
      end else begin
        stall++;
        if (SRAM_WE_N === 1'b0) we_low++;
        @(posedge clk); #1;
      end
    end
    check_val({tag, "_done"}, {31'b0, done}, 32'd1);
    check_val({tag, "_stall"}, stall, hit ? 32'd0 : WAIT + 1);
    check_val({tag, "_we_low"}, we_low, wr ? WAIT : 32'd0);
    check_val({tag, "_addr"}, {31'b0, addr_bad}, 32'd0);
    if (wr) begin
      ref_mem[int'(w)] = d;
    end else begin
      exp_data = ref_read(w);
      check_val({tag, "_rdata"}, rdata, exp_data);
      if (!hit) begin
        ref_rdata = exp_data;
        buf_valid = 1'b1;
        buf_word  = w;
      end
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    rd_en = 1'b0; wr_en = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_ready", {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time         t0;
    logic [31:0] a;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0; buf_valid = 1'b0; buf_word = '0;
    for (int i = 0; i < 524288; i++) sram_mem[i] = 32'h0;

    // Reset state
    @(negedge clk);
    check_val("rst_ready", {31'b0, ready}, 32'd1);
    check_val("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_addr", {13'b0, SRAM_Addr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles(1);

    // Back-to-back reads of preloaded words 0 and 1
    sram_mem[0] = 32'h11; ref_mem[0] = 32'h11;
    sram_mem[1] = 32'h22; ref_mem[1] = 32'h22;
    do_access(1'b0, 1'b1, BASE, 32'h0, "b2b0");
    t0 = t_ready;
    do_access(1'b0, 1'b1, BASE + 4, 32'h0, "b2b1");
    check_val("b2b_spacing", 32'((t_ready - t0) / 10), WAIT + 2);

    // Write then read
    do_access(1'b1, 1'b0, BASE + 8, 32'hDEADBEEF, "wr2");
    do_access(1'b0, 1'b1, BASE + 8, 32'h0, "rd2");

    // Simultaneous rd/wr is a write only
    do_access(1'b1, 1'b1, BASE + 12, 32'h12345678, "both3");
    check_val("both3_rdata_kept", rdata, ref_rdata);
    do_access(1'b0, 1'b1, BASE + 12, 32'h0, "rd3");

    // Address wrap onto word 0
    do_access(1'b1, 1'b0, BASE + 32'h0020_0000, 32'hCAFEF00D, "wrap_wr");
    do_access(1'b0, 1'b1, BASE, 32'h0, "wrap_rd");

`ifdef SRAM_READ_BUF_EN
    // Buffer hit, write-update, hit again
    do_access(1'b0, 1'b1, BASE + 20, 32'h0, "buf_miss5");
    do_access(1'b0, 1'b1, BASE + 20, 32'h0, "buf_hit5");
    do_access(1'b1, 1'b0, BASE + 20, 32'hA5A5A5A5, "buf_wr5");
    do_access(1'b0, 1'b1, BASE + 20, 32'h0, "buf_hit5b");
`endif

    // Randomized traffic over a small word set, with wrap aliases
    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h0020_0000;
      op = $urandom_range(0, 2);
      do_access(op != 0, op != 1, a, $urandom, "rnd");
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    // Reset in the middle of a write
    rd_en = 1'b0; wr_en = 1'b1; address = BASE + 400; wdata = 32'hFFFF0000;
    @(negedge clk);
    check_val("midwr_req_ready", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("midwr_we_low", {31'b0, SRAM_WE_N}, 32'd0);
    wr_en = 1'b0; rst = 1'b0;
    #1;
    check_val("midwr_rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
    check_val("midwr_rst_ready", {31'b0, ready}, 32'd1);
    check_val("midwr_rst_rdata", rdata, 32'h0);
    check_val("midwr_rst_addr", {13'b0, SRAM_Addr}, 32'h0);
    check_val("midwr_rst_dq", SRAM_DQ, ref_read(19'd0));
    ref_rdata = 32'h0; buf_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", {31'b0, ready}, 32'd1);
    check_val("post_rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, BASE + 12, 32'h0, "post_rst_rd3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
